adc_psram_writer: RTL and testbench
===================================

ADC_PSRAM_WRITER -- requirements
Module: adc_psram_writer

Interface
REQ-001 Parameter ADDR_W, default 21, PSRAM write-address width.
REQ-002 Parameter ADDR_INC, default 4, address increment per accepted word.
REQ-003 Parameter NUM_WORDS, default 1024, packed words per capture, minimum 1.
REQ-004 Parameter FIFO_DEPTH, default 4, power of two, word buffer depth.
REQ-005 clk_PSRAM  in  1  sole clock; all logic rising-edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 capture_start  in  1  one-cycle start pulse.
REQ-008 adc_ready  in  1  one-cycle sample-valid strobe from the ADC stage.
REQ-009 adc_data  in  12  sample value, valid when adc_ready=1.
REQ-010 adc_OTR  in  1  out-of-range flag, sampled with adc_data.
REQ-011 adc_enable  out  1  enable to the ADC stage.
REQ-012 wr_req  out  1  write request to the PSRAM controller.
REQ-013 wr_addr  out  ADDR_W  write address.
REQ-014 wr_data  out  64  packed write word.
REQ-015 wr_ack  in  1  controller accepts the current word.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 overflow  out  1  sticky word-dropped flag.

Function
REQ-019 States: IDLE, CAPTURE, DRAIN.
- IDLE->CAPTURE on capture_start.
- CAPTURE->DRAIN after the NUM_WORDS-th word completes.
- DRAIN->IDLE when the FIFO is empty and no request is pending.
REQ-020 On capture_start in IDLE, the block shall clear the lane index, word counter, wr_addr and overflow; capture_start outside IDLE shall be ignored.
REQ-021 adc_enable shall be high exactly while the state is CAPTURE, registered with the state.
REQ-022 Each adc_ready in CAPTURE shall place {adc_OTR, 3'b000, adc_data} into lane k (bits 16k+15:16k), with k=0 for the first sample of a word; adc_ready outside CAPTURE shall be ignored.
REQ-023 The fourth sample shall complete the word and push it into the FIFO in the same cycle, after which the lane index returns to 0.
REQ-024 wr_req shall be registered high the cycle after the FIFO becomes non-empty, so a completed word appears on wr_req one cycle after its fourth adc_ready.
REQ-025 wr_data and wr_addr shall be the FIFO head and current address, held stable while wr_req=1 and wr_ack=0.
REQ-026 wr_ack with wr_req=1 shall pop the FIFO and add ADDR_INC to wr_addr modulo 2^ADDR_W (wrap-around is silent).
REQ-027 wr_req shall fall in the cycle after acceptance if the FIFO is then empty; otherwise it shall stay high with the next word.
REQ-028 wr_ack with wr_req=0 shall be ignored.
REQ-029 If a word completes while the FIFO is full and no pop occurs that cycle, the word shall be dropped, overflow set, and the word counter still incremented.
REQ-030 A simultaneous push and pop when full shall accept the push.
REQ-031 done shall pulse for one cycle on the DRAIN->IDLE transition.
REQ-032 overflow shall hold until the next accepted capture_start or reset.

Reset
REQ-033 rst_n low shall asynchronously force:
- state IDLE
- adc_enable, wr_req, busy, done, overflow = 0
- wr_addr = 0, wr_data = 0
- FIFO empty, lane index and counters = 0
REQ-034 Reset mid-capture shall discard all buffered words with no further wr_req.
REQ-035 Reset deassertion shall take effect on the first clk_PSRAM edge after release.

Structure
REQ-036 Package adc_psram_pkg shall hold the lane width (16), word width (64), lanes per word (4) and the state encoding.
REQ-037 The FIFO shall be the sub-module word_fifo (synchronous, parameterised depth and width, full/empty outputs, rst_n asynchronous).

Verification
REQ-038 NUM_WORDS=2, wr_ack tied high, samples 0x123, 0x456, 0x789, 0xABC with OTR=0, then 4 more -> first word wr_data=0x0ABC078904560123 at wr_addr=0, second at wr_addr=4, then done pulse and adc_enable=0.
REQ-039 Sample 0xFFF with OTR=1 in lane 2 -> bits[47:32]=0x8FFF.
REQ-040 wr_ack held low for 30 cycles, FIFO_DEPTH=4, 20 samples -> words 1-4 buffered, word 5 dropped, overflow=1, wr_data stable throughout.
REQ-041 ADDR_W=4, ADDR_INC=4, NUM_WORDS=5 -> addresses 0, 4, 8, 12, 0.
REQ-042 rst_n pulsed low mid-CAPTURE with 2 words buffered -> wr_req, adc_enable and busy go 0 immediately, no writes afterward; a later capture_start restarts at address 0.
REQ-043 capture_start pulsed during CAPTURE and DRAIN -> no effect on counters, address or overflow.

Source files
------------

// File: rtl/adc_psram_writer_pkg.sv
// Shared widths and state encoding for the ADC-to-PSRAM capture writer.
package adc_psram_pkg;

  localparam int LANE_W = 16;
  localparam int WORD_W = 64;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/adc_psram_writer_if.sv
// Write-request channel from the capture writer to the PSRAM controller.
interface adc_psram_writer_if
  import adc_psram_pkg::*;
#(
  parameter int ADDR_W = 21
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ack;

  modport master (output wr_req, wr_addr, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);

endinterface

// File: rtl/adc_psram_writer_word_fifo.sv
// Synchronous word FIFO; DEPTH must be a power of two, at least 2.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk_PSRAM,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem[rd_q];

  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem[wr_q] <= din;
        wr_q      <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_psram_writer.sv
// Packs four 12-bit ADC samples (plus OTR) per 64-bit word and streams
// NUM_WORDS words per capture to the PSRAM controller through a small FIFO.
module adc_psram_writer
  import adc_psram_pkg::*;
#(
  parameter int ADDR_W     = 21,
  parameter int ADDR_INC   = 4,
  parameter int NUM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_PSRAM,
  input  logic                rst_n,
  input  logic                capture_start,
  input  logic                adc_ready,
  input  logic [11:0]         adc_data,
  input  logic                adc_OTR,
  output logic                adc_enable,
  adc_psram_writer_if.master  wr,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  state_t                     state_q, state_n;
  logic [1:0]                 lane_q;
  logic [LANE_W*(LANES-1)-1:0] acc_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [ADDR_W-1:0]          addr_q;
  logic                       adc_en_q, done_q, ovf_q;

  logic                       start_ok, take, word_done, last_word;
  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [LANE_W-1:0]          sample;
  logic [WORD_W-1:0]          word, fifo_dout;

  assign start_ok  = capture_start && (state_q == IDLE);
  assign take      = adc_ready && (state_q == CAPTURE);
  assign word_done = take && (lane_q == 2'(LANES - 1));
  assign last_word = word_done && (cnt_q == CNT_W'(NUM_WORDS - 1));
  assign sample    = {adc_OTR, 3'b000, adc_data};
  assign word      = {sample, acc_q};

  // A pop in the same cycle frees a slot, so a completing word is never dropped then.
  assign fifo_pop  = wr.wr_req && wr.wr_ack;
  assign fifo_push = word_done && (!fifo_full || fifo_pop);
  assign drop      = word_done && fifo_full && !fifo_pop;

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_PSRAM (clk_PSRAM),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (word),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (capture_start) state_n = CAPTURE;
      CAPTURE: if (last_word)     state_n = DRAIN;
      DRAIN:   if (fifo_empty)    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      adc_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      lane_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_n;
      adc_en_q <= (state_n == CAPTURE);
      done_q   <= (state_q == DRAIN) && (state_n == IDLE);
      if (start_ok) begin
        lane_q <= '0;
        cnt_q  <= '0;
        addr_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (word_done) begin
          lane_q <= '0;
          cnt_q  <= cnt_q + CNT_W'(1);
        end else if (take) begin
          acc_q[lane_q*LANE_W +: LANE_W] <= sample;
          lane_q <= lane_q + 2'd1;
        end
        if (fifo_pop) addr_q <= addr_q + ADDR_W'(ADDR_INC);
        if (drop)     ovf_q  <= 1'b1;
      end
    end
  end

  assign wr.wr_req  = !fifo_empty;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = fifo_dout;
  assign adc_enable = adc_en_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_psram_writer.sv
// Directed bench: two DUT configurations share the ADC-side stimulus.
module tb_adc_psram_writer;
  import adc_psram_pkg::*;

  logic        clk_PSRAM = 1'b0;
  logic        rst_n, capture_start, adc_ready, adc_OTR, wr_ack;
  logic [11:0] adc_data;
  logic        en_a, busy_a, done_a, ovf_a;
  logic        en_b, busy_b, done_b, ovf_b;

  int n_checks = 0;
  int n_errors = 0;

  adc_psram_writer_if #(.ADDR_W(21)) bus_a ();
  adc_psram_writer_if #(.ADDR_W(4))  bus_b ();
  assign bus_a.wr_ack = wr_ack;
  assign bus_b.wr_ack = wr_ack;

  adc_psram_writer #(.ADDR_W(21), .ADDR_INC(4), .NUM_WORDS(2), .FIFO_DEPTH(4)) dut_a (
    .clk_PSRAM(clk_PSRAM), .rst_n(rst_n), .capture_start(capture_start),
    .adc_ready(adc_ready), .adc_data(adc_data), .adc_OTR(adc_OTR),
    .adc_enable(en_a), .wr(bus_a.master), .busy(busy_a), .done(done_a), .overflow(ovf_a)
  );

  adc_psram_writer #(.ADDR_W(4), .ADDR_INC(4), .NUM_WORDS(5), .FIFO_DEPTH(4)) dut_b (
    .clk_PSRAM(clk_PSRAM), .rst_n(rst_n), .capture_start(capture_start),
    .adc_ready(adc_ready), .adc_data(adc_data), .adc_OTR(adc_OTR),
    .adc_enable(en_b), .wr(bus_b.master), .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  always #5 clk_PSRAM = ~clk_PSRAM;

  typedef struct {
    logic [3:0][11:0] d;
    logic [3:0]       o;
    logic [63:0]      exp;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_PSRAM);
    #1;
  endtask

  task automatic sample(input logic [11:0] d, input logic o);
    adc_ready = 1'b1;
    adc_data  = d;
    adc_OTR   = o;
    tick();
    adc_ready = 1'b0;
  endtask

  task automatic start();
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
  endtask

  // Ramp stimulus uses sample value k+1, OTR=0, so lane contents equal the sample.
  function automatic logic [63:0] ramp_word(input int j);
    return {16'(4*j+4), 16'(4*j+3), 16'(4*j+2), 16'(4*j+1)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int unstable;
    int writes;
    int n;

    rst_n = 1'b0; capture_start = 1'b0; adc_ready = 1'b0;
    adc_data = '0; adc_OTR = 1'b0; wr_ack = 1'b0;

    tbl[0] = '{d: {12'hABC, 12'h789, 12'h456, 12'h123}, o: 4'b0000, exp: 64'h0ABC_0789_0456_0123};
    tbl[1] = '{d: {12'h222, 12'hFFF, 12'h111, 12'h000}, o: 4'b0100, exp: 64'h0222_8FFF_0111_0000};
    tbl[2] = '{d: {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, o: 4'b1111, exp: 64'h8FFF_8FFF_8FFF_8FFF};
    tbl[3] = '{d: {12'h000, 12'h7FF, 12'h800, 12'h001}, o: 4'b1010, exp: 64'h8000_07FF_8800_0001};
    tbl[4] = '{d: {12'hF0F, 12'h0F0, 12'h5A5, 12'hA5A}, o: 4'b0000, exp: 64'h0F0F_00F0_05A5_0A5A};

    repeat (2) tick();
    chk("rst_wr_req_b",  bus_b.wr_req,  0);
    chk("rst_wr_addr_b", bus_b.wr_addr, 0);
    chk("rst_wr_data_b", bus_b.wr_data, 0);
    chk("rst_adc_en_b",  en_b,   0);
    chk("rst_busy_b",    busy_b, 0);
    chk("rst_done_b",    done_b, 0);
    chk("rst_ovf_b",     ovf_b,  0);
    chk("rst_wr_req_a",  bus_a.wr_req, 0);

    rst_n = 1'b1;
    tick();
    wr_ack = 1'b1;
    start();
    chk("start_en_a",   en_a,   1);
    chk("start_en_b",   en_b,   1);
    chk("start_busy_b", busy_b, 1);

    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 4; s++) sample(tbl[i].d[s], tbl[i].o[s]);
      chk($sformatf("tbl_req_b[%0d]", i),  bus_b.wr_req, 1);
      chk($sformatf("tbl_data_b[%0d]", i), bus_b.wr_data, tbl[i].exp);
      chk($sformatf("tbl_addr_b[%0d]", i), bus_b.wr_addr, 64'((4*i) % 16));
      if (i < 2) begin
        chk($sformatf("tbl_data_a[%0d]", i), bus_a.wr_data, tbl[i].exp);
        chk($sformatf("tbl_addr_a[%0d]", i), bus_a.wr_addr, 64'(4*i));
      end
      if (i == 1) begin
        chk("lane2_otr", bus_b.wr_data[47:32], 16'h8FFF);
        start();
        for (int c = 0; c < 8 && done_a !== 1'b1; c++) tick();
        chk("done_a",          done_a, 1);
        chk("drain_en_a",      en_a,   0);
        chk("drain_addr_a",    bus_a.wr_addr, 8);
        chk("drain_ovf_a",     ovf_a,  0);
        chk("ign_start_en_b",  en_b,   1);
        chk("ign_start_addr_b", bus_b.wr_addr, 8);
      end
    end
    for (int c = 0; c < 8 && done_b !== 1'b1; c++) tick();
    chk("done_b",       done_b, 1);
    chk("wrap_addr_b",  bus_b.wr_addr, 4);
    chk("end_en_b",     en_b,   0);
    chk("end_busy_b",   busy_b, 0);

    // Back-pressure: ack low for 30 cycles while 20 samples arrive.
    wr_ack = 1'b0;
    start();
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      sample(12'(k + 1), 1'b0);
      if (k >= 3 && (bus_b.wr_data !== ramp_word(0) || bus_b.wr_req !== 1'b1)) unstable++;
    end
    repeat (10) begin
      tick();
      if (bus_b.wr_data !== ramp_word(0) || bus_b.wr_req !== 1'b1) unstable++;
    end
    chk("bp_stable",  unstable, 0);
    chk("bp_ovf",     ovf_b,    1);
    chk("bp_addr",    bus_b.wr_addr, 0);
    chk("bp_en",      en_b,     0);
    chk("bp_busy",    busy_b,   1);
    wr_ack = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bp_data[%0d]", j), bus_b.wr_data, ramp_word(j));
      chk($sformatf("bp_waddr[%0d]", j), bus_b.wr_addr, 64'(4*j));
      tick();
    end
    chk("bp_req_low", bus_b.wr_req, 0);
    for (int c = 0; c < 8 && done_b !== 1'b1; c++) tick();
    chk("bp_done",    done_b, 1);
    chk("ovf_sticky", ovf_b,  1);

    wr_ack = 1'b0;
    start();
    chk("ovf_cleared", ovf_b, 0);
    chk("addr_cleared", bus_b.wr_addr, 0);

    // Full FIFO with push and pop in the same cycle keeps the new word.
    for (int k = 0; k < 19; k++) sample(12'(k + 1), 1'b0);
    chk("full_head", bus_b.wr_data, ramp_word(0));
    wr_ack = 1'b1;
    sample(12'd20, 1'b0);
    wr_ack = 1'b0;
    chk("pp_ovf",  ovf_b, 0);
    chk("pp_data", bus_b.wr_data, ramp_word(1));
    chk("pp_addr", bus_b.wr_addr, 4);
    wr_ack = 1'b1;
    n = 0;
    for (int c = 0; c < 12 && busy_b === 1'b1; c++) begin
      if (bus_b.wr_req === 1'b1) begin
        chk($sformatf("pp_drain[%0d]", n), bus_b.wr_data, ramp_word(1 + n));
        n++;
      end
      tick();
    end
    chk("pp_count", n, 4);

    // Asynchronous reset with two words buffered.
    wr_ack = 1'b0;
    start();
    for (int k = 0; k < 8; k++) sample(12'(k + 1), 1'b0);
    chk("pre_rst_req",  bus_b.wr_req, 1);
    chk("pre_rst_busy", busy_b, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",  bus_b.wr_req, 0);
    chk("arst_en",   en_b,   0);
    chk("arst_busy", busy_b, 0);
    chk("arst_data", bus_b.wr_data, 0);
    wr_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    writes = 0;
    repeat (6) begin
      tick();
      if (bus_b.wr_req !== 1'b0) writes++;
    end
    chk("post_rst_writes", writes, 0);
    start();
    for (int s = 0; s < 4; s++) sample(tbl[0].d[s], tbl[0].o[s]);
    chk("restart_req",  bus_b.wr_req, 1);
    chk("restart_addr", bus_b.wr_addr, 0);
    chk("restart_data", bus_b.wr_data, tbl[0].exp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
